// File: rtl/gb_hdmi_pkg.sv
// Shared constants and types for the GameBoy-to-HDMI scaler: frame geometry,
// framebuffer addressing and the 36-bit RGB pixel format.
package gb_hdmi_pkg;

    localparam int GB_W   = 160;
    localparam int GB_H   = 144;
    localparam int SCALE  = 3;
    localparam int GB_PIX = GB_W * GB_H;
    localparam int ACT_W  = 720;
    localparam int ACT_H  = 480;

    typedef logic [1:0]  shade_t;
    typedef logic [14:0] fb_addr_t;
    typedef logic [35:0] rgb36_t;

endpackage

// File: rtl/gb_frame_ram.sv
// One GameBoy frame of 2-bit shades: simple dual-port, single clock, registered
// read. A same-cycle read of the address being written returns the old shade.
module gb_frame_ram
    import gb_hdmi_pkg::*;
(
    input  logic     clk,
    input  logic     wr_en,
    input  fb_addr_t wr_addr,
    input  shade_t   wr_data,
    input  fb_addr_t rd_addr,
    output shade_t   rd_data
);

    shade_t mem [GB_PIX];
    shade_t rd_data_q;

    // No reset on the array or the read register so the tools map it onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/gb_hdmi_scaler.sv
// Stores a 160x144 GameBoy frame, upscales it 3x into a window of the 720x480
// active area and re-emits the incoming timing two cycles later with RGB data.
module gb_hdmi_scaler
    import gb_hdmi_pkg::*;
#(
    parameter int     H_OFF  = 120,
    parameter int     V_OFF  = 24,
    parameter rgb36_t BORDER = 36'h0,
    parameter rgb36_t PAL0   = 36'hFFF_FFF_FFF,
    parameter rgb36_t PAL1   = 36'hAAA_AAA_AAA,
    parameter rgb36_t PAL2   = 36'h555_555_555,
    parameter rgb36_t PAL3   = 36'h000_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [1:0]  pix_data,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [35:0] data,
    output logic        wr_ovf
);

    localparam int X_W    = $clog2(ACT_W);
    localparam int LINE_W = $clog2(ACT_H) + 1;

    localparam logic [X_W-1:0]    X_LO     = X_W'(H_OFF);
    localparam logic [X_W-1:0]    X_HI     = X_W'(H_OFF + GB_W * SCALE);
    localparam logic [X_W-1:0]    X_MAX    = X_W'(ACT_W - 1);
    localparam logic [LINE_W-1:0] Y_LO     = LINE_W'(V_OFF);
    localparam logic [LINE_W-1:0] Y_HI     = LINE_W'(V_OFF + GB_H * SCALE);
    localparam logic [1:0]        SUB_LAST = 2'(SCALE - 1);
    localparam fb_addr_t          FB_END   = fb_addr_t'(GB_PIX);
    localparam fb_addr_t          ROW_STEP = fb_addr_t'(GB_W);

    // ---------------- write side ----------------
    fb_addr_t wr_addr_q, wr_addr_d;
    logic     wr_ovf_q, wr_ovf_d;
    fb_addr_t ram_wr_addr;
    logic     ram_wr_en;

    // The address saturates at the end of the frame, so a runaway PPU can never
    // wrap around and overwrite the top of the image.
    always_comb begin
        wr_addr_d   = wr_addr_q;
        wr_ovf_d    = wr_ovf_q;
        ram_wr_en   = 1'b0;
        ram_wr_addr = pix_sof ? '0 : wr_addr_q;
        if (pix_valid) begin
            if (pix_sof) begin
                wr_ovf_d = 1'b0;
            end
            if (ram_wr_addr < FB_END) begin
                ram_wr_en = 1'b1;
                wr_addr_d = ram_wr_addr + fb_addr_t'(1);
            end else begin
                wr_ovf_d = 1'b1;
            end
        end
    end

    // ---------------- scan counters and window ----------------
    logic [X_W-1:0]    x_q, x_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              de_prev_q, vs_prev_q;
    logic [1:0]        hsub_q, hsub_d, vsub_q, vsub_d;
    logic [7:0]        gx_q, gx_d, gy_q, gy_d;
    fb_addr_t          row_base_q, row_base_d;
    logic              de_fall, vs_fall, h_in, v_in, in_win;
    fb_addr_t          rd_addr;

    assign de_fall = de_prev_q & ~de_in;
    assign vs_fall = vs_prev_q & ~vsync_in;
    assign h_in    = (x_q >= X_LO) && (x_q < X_HI);
    assign v_in    = (line_q >= Y_LO) && (line_q < Y_HI);
    assign in_win  = de_in & h_in & v_in;
    assign rd_addr = row_base_q + fb_addr_t'(gx_q);

    always_comb begin
        x_d        = '0;
        line_d     = line_q;
        hsub_d     = '0;
        gx_d       = '0;
        vsub_d     = vsub_q;
        gy_d       = gy_q;
        row_base_d = row_base_q;

        if (de_in) begin
            x_d = (x_q == X_MAX) ? '0 : x_q + X_W'(1);
        end

        if (vs_fall) begin
            line_d = '0;
        end else if (de_fall) begin
            line_d = line_q + LINE_W'(1);
        end

        // Horizontal replication; leaving the window clears it for the next row.
        if (in_win) begin
            if (hsub_q == SUB_LAST) begin
                gx_d = gx_q + 8'd1;
            end else begin
                hsub_d = hsub_q + 2'd1;
                gx_d   = gx_q;
            end
        end

        // Vertical replication steps once per window line, at that line's end.
        if (vs_fall) begin
            vsub_d     = '0;
            gy_d       = '0;
            row_base_d = '0;
        end else if (de_fall && v_in) begin
            if (vsub_q == SUB_LAST) begin
                vsub_d     = '0;
                gy_d       = gy_q + 8'd1;
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                vsub_d = vsub_q + 2'd1;
            end
        end
    end

    // ---------------- output pipeline ----------------
    shade_t rd_shade;
    rgb36_t pal_rgb;
    logic   hs1_q, vs1_q, de1_q, win1_q;
    logic   hs1_d, vs1_d, de1_d, win1_d;
    logic   hs2_q, vs2_q, de2_q;
    logic   hs2_d, vs2_d, de2_d;
    rgb36_t data_q, data_d;

    always_comb begin
        hs1_d  = hsync_in;
        vs1_d  = vsync_in;
        de1_d  = de_in;
        win1_d = in_win;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        de2_d  = de1_q;

        case (rd_shade)
            2'd0:    pal_rgb = PAL0;
            2'd1:    pal_rgb = PAL1;
            2'd2:    pal_rgb = PAL2;
            default: pal_rgb = PAL3;
        endcase

        data_d = '0;
        if (de1_q) begin
            data_d = win1_q ? pal_rgb : BORDER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            wr_ovf_q   <= 1'b0;
            x_q        <= '0;
            line_q     <= '0;
            de_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b1;
            hsub_q     <= '0;
            gx_q       <= '0;
            vsub_q     <= '0;
            gy_q       <= '0;
            row_base_q <= '0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            de1_q      <= 1'b0;
            win1_q     <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            de2_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            wr_ovf_q   <= wr_ovf_d;
            x_q        <= x_d;
            line_q     <= line_d;
            de_prev_q  <= de_in;
            vs_prev_q  <= vsync_in;
            hsub_q     <= hsub_d;
            gx_q       <= gx_d;
            vsub_q     <= vsub_d;
            gy_q       <= gy_d;
            row_base_q <= row_base_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            de1_q      <= de1_d;
            win1_q     <= win1_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            de2_q      <= de2_d;
            data_q     <= data_d;
        end
    end

    gb_frame_ram u_frame_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (pix_data),
        .rd_addr (rd_addr),
        .rd_data (rd_shade)
    );

    assign hsync  = hs2_q;
    assign vsync  = vs2_q;
    assign de     = de2_q;
    assign data   = data_q;
    assign wr_ovf = wr_ovf_q;

endmodule

// File: tb/tb_gb_hdmi_scaler.sv
// Bench for gb_hdmi_scaler: a compressed 720-wide raster (short lines except a few
// full ones) checked every cycle against a coordinate-based model of the scaled image.
`timescale 1ns/1ps
module tb_gb_hdmi_scaler;

    localparam int          NPIX     = 23040;
    localparam int          LAST_V   = 487;
    localparam logic [35:0] BORDER_C = 36'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [1:0]  pix_data = 2'd0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        de_in = 1'b0;
    logic        hsync, vsync, de, wr_ovf;
    logic [35:0] data;

    int checks = 0;
    int errors = 0;
    int lit_hits = 0;
    int cur_v = 0;
    int cur_h = 0;
    logic data_chk = 1'b0;
    logic synced = 1'b0;
    logic [1:0] fb_model [NPIX];

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic [35:0] data;
        logic        dknown;
        int          x;
        int          y;
    } exp_t;

    always #5 clk = ~clk;

    gb_hdmi_scaler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_data  (pix_data),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .de_in     (de_in),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .data      (data),
        .wr_ovf    (wr_ovf)
    );

    function automatic logic [35:0] pal(input logic [1:0] s);
        case (s)
            2'd0:    return 36'hFFF_FFF_FFF;
            2'd1:    return 36'hAAA_AAA_AAA;
            2'd2:    return 36'h555_555_555;
            default: return 36'h000_000_000;
        endcase
    endfunction

    function automatic exp_t rst_entry();
        exp_t r;
        r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0; r.data = '0;
        r.dknown = 1'b1; r.x = -1; r.y = -1;
        return r;
    endfunction

    // de width per line: a handful of full 720-pixel lines around the image edges.
    function automatic int line_w(input int v);
        if (v == 23 || v == 24 || v == 25 || v == 26 || v == 27 ||
            v == 200 || v == 300 || v == 455 || v == 456) return 720;
        return 4;
    endfunction

    task automatic chk1(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, want);
        end
    endtask

    task automatic lit_chk(input string nm, input int x, input int y,
                           input logic [35:0] got, input logic [35:0] want);
        checks++;
        lit_hits++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (%0d,%0d): got %h expected %h", nm, x, y, got, want);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_hsync"}, hsync, 1'b1);
        chk1({tag, "_vsync"}, vsync, 1'b1);
        chk1({tag, "_de"}, de, 1'b0);
        checks++;
        if (data !== 36'h0) begin
            errors++;
            $display("FAIL %s_data: got %h expected 0", tag, data);
        end
        chk1({tag, "_wr_ovf"}, wr_ovf, 1'b0);
    endtask

    task automatic wait_pos(input int tv, input int th, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(cur_v == tv && cur_h == th) && n < 30000);
        checks++;
        if (n >= 30000) begin
            errors++;
            $display("FAIL %s: timeout waiting for line %0d col %0d", nm, tv, th);
        end
    endtask

    // Timing generator plus per-cycle compare of the outputs two cycles later.
    initial begin : video
        exp_t h0, h1, e, nx;
        int   v, h, lw, lt;
        logic hs_n, vs_n, de_n, vs_prev_drv;
        h0 = rst_entry();
        h1 = rst_entry();
        v = 0;
        h = 0;
        vs_prev_drv = 1'b1;
        forever begin
            @(negedge clk);
            e = rst_n ? h1 : rst_entry();
            checks++;
            if ({hsync, vsync, de} !== {e.hs, e.vs, e.de}) begin
                errors++;
                $display("FAIL sync (%0d,%0d): got hs/vs/de %b%b%b expected %b%b%b",
                         e.x, e.y, hsync, vsync, de, e.hs, e.vs, e.de);
            end
            if (!e.de || e.dknown) begin
                checks++;
                if (data !== e.data) begin
                    errors++;
                    $display("FAIL data (%0d,%0d): got %h expected %h", e.x, e.y, data, e.data);
                end
            end
            if (e.de && e.dknown) begin
                if (e.x >= 120 && e.x <= 122 && e.y >= 24 && e.y <= 26)
                    lit_chk("lit_blk0_pal0", e.x, e.y, data, 36'hFFF_FFF_FFF);
                else if (e.x == 123 && e.y == 24)
                    lit_chk("lit_gx1_pal1", e.x, e.y, data, 36'hAAA_AAA_AAA);
                else if (e.x == 599 && e.y == 455)
                    lit_chk("lit_last_pal2", e.x, e.y, data, 36'h555_555_555);
                else if ((e.x == 119 && e.y == 24) || (e.x == 120 && e.y == 23))
                    lit_chk("lit_border", e.x, e.y, data, 36'h0);
            end

            if (v < 480) begin
                lw   = line_w(v);
                de_n = (h < lw);
                hs_n = !(h >= lw + 2 && h < lw + 6);
                lt   = lw + 8;
            end else begin
                de_n = 1'b0;
                hs_n = !(h >= 4 && h < 8);
                lt   = 20;
            end
            vs_n = !(v >= 482 && v <= 484);
            hsync_in = hs_n;
            vsync_in = vs_n;
            de_in    = de_n;
            cur_v    = v;
            cur_h    = h;

            if (!rst_n) synced = 1'b0;
            else if (vs_prev_drv && !vs_n) synced = 1'b1;
            vs_prev_drv = vs_n;

            if (!rst_n) begin
                nx = rst_entry();
            end else begin
                nx.hs = hs_n; nx.vs = vs_n; nx.de = de_n;
                nx.x = h; nx.y = v;
                nx.dknown = synced && data_chk;
                if (!de_n)
                    nx.data = '0;
                else if (h >= 120 && h < 600 && v >= 24 && v < 456)
                    nx.data = pal(fb_model[((v - 24) / 3) * 160 + (h - 120) / 3]);
                else
                    nx.data = BORDER_C;
            end
            h1 = h0;
            h0 = nx;

            h++;
            if (h == lt) begin
                h = 0;
                v = (v == LAST_V) ? 0 : v + 1;
            end
        end
    end

    initial begin : main
        rst_n = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Fill with shade (x+y)%4, then one pixel past the end of the frame.
        for (int i = 0; i <= NPIX; i++) begin
            @(posedge clk);
            #2;
            if (i == 1)    chk1("ovf_after_sof_pixel", wr_ovf, 1'b0);
            if (i == NPIX) chk1("ovf_at_23040", wr_ovf, 1'b0);
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            if (i < NPIX) begin
                pix_data    = 2'((i % 160 + i / 160) % 4);
                fb_model[i] = pix_data;
            end else begin
                pix_data = 2'd3;
            end
        end
        @(posedge clk);
        #2;
        chk1("ovf_at_23041", wr_ovf, 1'b1);
        pix_valid = 1'b0;
        pix_sof   = 1'b1;
        pix_data  = 2'd3;
        @(posedge clk);
        #2;
        chk1("ovf_sof_without_valid", wr_ovf, 1'b1);
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_data  = 2'd0;
        @(posedge clk);
        #2;
        chk1("ovf_cleared_by_sof", wr_ovf, 1'b0);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(posedge clk);
        #2;
        chk1("ovf_stays_clear", wr_ovf, 1'b0);
        data_chk = 1'b1;

        // Let the current frame finish and one complete frame be compared.
        wait_pos(479, 0, "frame_a_end");
        wait_pos(479, 0, "frame_b_end");

        // Reset in the middle of a full-width window line.
        wait_pos(200, 300, "line200");
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;

        // Misaligned remainder of this frame, then a full frame after the vsync fall.
        wait_pos(479, 0, "frame_c_end");
        wait_pos(479, 0, "frame_d_end");
        repeat (4) @(posedge clk);

        checks++;
        if (lit_hits < 26) begin
            errors++;
            $display("FAIL lit_coverage: got %0d literal pixels expected at least 26", lit_hits);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
